// File: rtl/seg_scan_display.sv
// seg_scan_display: N-digit decimal 7-segment scan driver with double-dabble conversion (optional LEADING_ZERO_BLANK_EN blanks leading zeros)
module seg_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int IN_WIDTH   = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   num,
  input  logic                  load,
  output logic                  busy,
  output logic                  err,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'b0000001;
      4'd1: glyph = 7'b1001111;
      4'd2: glyph = 7'b0010010;
      4'd3: glyph = 7'b0000110;
      4'd4: glyph = 7'b1001100;
      4'd5: glyph = 7'b0100100;
      4'd6: glyph = 7'b0100000;
      4'd7: glyph = 7'b0001111;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0000100;
      default: glyph = 7'b1111111;
    endcase
  endfunction
  localparam int BW = (NUM_DIGITS + 1) * 4;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [3:0] BLANK = 4'hF;
  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;
  state_t              state_q;
  logic [IN_WIDTH-1:0] bin_q, cap_q;
  logic [BW-1:0]       bcd_q, adj;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, err_q, ovf;
  logic [3:0]          disp_q [NUM_DIGITS];
  logic [3:0]          disp_d [NUM_DIGITS];
  logic [SW-1:0]       scnt_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                term;
  assign busy = busy_q;
  assign err  = err_q;
  assign seg  = seg_q;
  assign an   = an_q;
  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS + 1; k++)
      adj[k*4 +: 4] = bcd_q[k*4 +: 4] >= 4'd5 ? bcd_q[k*4 +: 4] + 4'd3 : bcd_q[k*4 +: 4];
  end
  // Next display contents: blank everywhere on overflow, optionally blank leading zeros
  always_comb begin
    disp_d = '{default: BLANK};
    ovf = bcd_q[BW-1 -: 4] != 4'd0 || 64'(cap_q) > MAX_VAL;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
        lead = lead && bcd_q[k*4 +: 4] == 4'd0 && k != 0;
        disp_d[k] = ovf || lead ? BLANK : bcd_q[k*4 +: 4];
      end
    end
`else
    for (int k = 0; k < NUM_DIGITS; k++)
      disp_d[k] = ovf ? BLANK : bcd_q[k*4 +: 4];
`endif
  end
  // Capture / convert / publish FSM; display registers change only in UPDATE so the scan is never mixed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      disp_q  <= '{default: BLANK};
    end else begin
      case (state_q)
        IDLE: if (load) begin
          bin_q   <= num;
          cap_q   <= num;
          bcd_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CONVERT;
        end
        CONVERT: begin
          {bcd_q, bin_q} <= {adj, bin_q} << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(IN_WIDTH - 1)) state_q <= UPDATE;
        end
        UPDATE: begin
          err_q   <= ovf;
          disp_q  <= disp_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign term  = scnt_q == SW'(SCAN_DIV - 1);
  assign idx_d = !term ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
  // Free-running scanner; seg/an are registered from the next index so they move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= 7'b1111111;
      an_q   <= '1;
    end else begin
      scnt_q <= term ? '0 : scnt_q + 1'b1;
      idx_q  <= idx_d;
      an_q   <= ~(NUM_DIGITS'(1) << idx_d);
      seg_q  <= glyph(disp_q[idx_d]);
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of conversion, overflow, load-ignore, reset and digit scanning
module tb_seg_scan_display;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [13:0] num = '0;
  logic busy, err;
  logic [6:0] seg;
  logic [3:0] an;
  int passes = 0, total = 0;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif
  seg_scan_display #(.NUM_DIGITS(4), .IN_WIDTH(14), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .load(load),
    .busy(busy), .err(err), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic scan_chk(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                          input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] g [4];
    logic [3:0] prev, ea;
    int n;
    g = '{d0, d1, d2, d3};
    prev = an;
    n = 0;
    @(negedge clk);
    while (!(an == 4'b1110 && prev == 4'b0111) && n < 60) begin
      prev = an;
      n++;
      @(negedge clk);
    end
    chk({tag, " sync"}, 32'(n < 60), 32'd1);
    for (int k = 0; k < 16; k++) begin
      ea = ~(4'b0001 << (k / 4));
      chk({tag, " an"}, 32'(an), 32'(ea));
      chk({tag, " seg"}, 32'(seg), 32'(g[k/4]));
      @(negedge clk);
    end
  endtask
  task automatic do_load(input logic [13:0] v, output int n);
    num = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    int n;
    logic hit;
    repeat (3) @(negedge clk);
    chk("rst seg", 32'(seg), 32'(BL));
    chk("rst an", 32'(an), 32'hF);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    rst_n = 1'b1;
    scan_chk("blank after rst", BL, BL, BL, BL);
    do_load(14'd1234, n);
    chk("1234 busy cycles", n, 32'd15);
    chk("1234 err", 32'(err), 32'd0);
    scan_chk("1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);
    do_load(14'd10000, n);
    chk("10000 busy cycles", n, 32'd15);
    chk("10000 err", 32'(err), 32'd1);
    scan_chk("10000", BL, BL, BL, BL);
    do_load(14'd9999, n);
    chk("9999 err", 32'(err), 32'd0);
    scan_chk("9999", 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100);
    do_load(14'd7, n);
    chk("7 err", 32'(err), 32'd0);
    scan_chk("7", 7'b0001111, LZ, LZ, LZ);
    num = 14'd42;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 5) begin
        num = 14'd99;
        load = 1'b1;
      end else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    chk("42 busy cycles", n, 32'd15);
    @(negedge clk);
    chk("42 busy after", 32'(busy), 32'd0);
    scan_chk("42", 7'b0010010, 7'b1001100, LZ, LZ);
    num = 14'd55;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    hit = 1'b0;
    while (busy && n < 40 && !hit) begin
      n++;
      if (n == 8) hit = 1'b1;
      else @(negedge clk);
    end
    chk("55 reached cycle 8", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst seg", 32'(seg), 32'(BL));
    chk("midrst an", 32'(an), 32'hF);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scan_chk("blank after midrst", BL, BL, BL, BL);
    chk("idle busy", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
